// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Covers opcodes, functs, REGIMM rt codes, ALU functions, FSM states and instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU functions reuse the R-type funct codes; branches and jumps use the 0x38-0x3F range
    localparam logic [5:0] F_NONE = 6'h00;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;
    localparam logic [5:0] FBLTZ  = 6'h38;
    localparam logic [5:0] FBGEZ  = 6'h39;
    localparam logic [5:0] FJ     = 6'h3B;
    localparam logic [5:0] FBEQ   = 6'h3C;
    localparam logic [5:0] FBNE   = 6'h3D;
    localparam logic [5:0] FBLEZ  = 6'h3E;
    localparam logic [5:0] FBGTZ  = 6'h3F;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_ALUI,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_JUMP_LINK,
        CL_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier for the multi-cycle control FSM.
// Maps opcode/funct/rt to class, ALU function and datapath selects.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [4:0]   rt,
    output instr_class_e instr_class,
    output logic [5:0]   alu_function,
    output logic [1:0]   word_size,
    output logic         load_signed,
    output logic         is_signed,
    output logic         is_lui,
    output logic         is_jump_reg
);

    always_comb begin
        instr_class  = CL_ILLEGAL;
        alu_function = F_NONE;
        word_size    = 2'b11;
        load_signed  = 1'b0;
        is_signed    = 1'b1;
        is_lui       = 1'b0;
        is_jump_reg  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        instr_class  = CL_ALU;
                        alu_function = funct;
                    end
                    FN_JR: begin
                        instr_class  = CL_JUMP;
                        alu_function = FJ;
                        is_jump_reg  = 1'b1;
                    end
                    FN_JALR: begin
                        instr_class  = CL_JUMP_LINK;
                        alu_function = FJ;
                        is_jump_reg  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ) begin
                    instr_class  = CL_BRANCH;
                    alu_function = FBLTZ;
                end else if (rt == RT_BGEZ) begin
                    instr_class  = CL_BRANCH;
                    alu_function = FBGEZ;
                end
            end
            OP_J:    begin instr_class = CL_JUMP;      alu_function = FJ;    end
            OP_JAL:  begin instr_class = CL_JUMP_LINK; alu_function = FJ;    end
            OP_BEQ:  begin instr_class = CL_BRANCH;    alu_function = FBEQ;  end
            OP_BNE:  begin instr_class = CL_BRANCH;    alu_function = FBNE;  end
            OP_BLEZ: begin instr_class = CL_BRANCH;    alu_function = FBLEZ; end
            OP_BGTZ: begin instr_class = CL_BRANCH;    alu_function = FBGTZ; end
            OP_ADDI:  begin instr_class = CL_ALUI; alu_function = F_ADD;  end
            OP_ADDIU: begin instr_class = CL_ALUI; alu_function = F_ADDU; end
            OP_SLTI:  begin instr_class = CL_ALUI; alu_function = F_SLT;  end
            OP_SLTIU: begin instr_class = CL_ALUI; alu_function = F_SLTU; end
            OP_ANDI: begin instr_class = CL_ALUI; alu_function = F_AND; is_signed = 1'b0; end
            OP_ORI:  begin instr_class = CL_ALUI; alu_function = F_OR;  is_signed = 1'b0; end
            OP_XORI: begin instr_class = CL_ALUI; alu_function = F_XOR; is_signed = 1'b0; end
            OP_LUI: begin
                instr_class  = CL_ALUI;
                alu_function = F_ADD;
                is_signed    = 1'b0;
                is_lui       = 1'b1;
            end
            // Only stores narrow word_size; signed loads are told apart by load_signed
            OP_LB, OP_LH: begin
                instr_class  = CL_LOAD;
                alu_function = F_ADD;
                load_signed  = 1'b1;
            end
            OP_LW, OP_LBU, OP_LHU: begin
                instr_class  = CL_LOAD;
                alu_function = F_ADD;
            end
            OP_SB: begin instr_class = CL_STORE; alu_function = F_ADD; word_size = 2'b00; end
            OP_SH: begin instr_class = CL_STORE; alu_function = F_ADD; word_size = 2'b01; end
            OP_SW: begin instr_class = CL_STORE; alu_function = F_ADD; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky TRAP and retire counter.
// Define MULTICYCLE_CONTROL_MEM_WAIT_EN to stretch FETCH and MEM until mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int W     = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     opcode_in,
    input  logic [W-1:0]     funct_in,
    input  logic [4:0]       rt,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write_enabled,
    output logic             uses_immediate_in_alu,
    output logic             is_r_type,
    output logic             is_link,
    output logic             is_jump_reg,
    output logic             is_lui,
    output logic             is_signed,
    output logic             load_signed,
    output logic [W-1:0]     alu_function,
    output logic [1:0]       word_size,
    output logic [2:0]       state,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count,
    output logic             illegal_instr
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_count_q, retired_count_d;
    logic             mem_ok;

    instr_class_e dec_class;
    logic [5:0]   dec_alu_function;
    logic [1:0]   dec_word_size;
    logic         dec_load_signed, dec_is_signed, dec_is_lui, dec_is_jump_reg;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_ok           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    mc_decode u_decode (
        .opcode       (opcode_in),
        .funct        (funct_in),
        .rt           (rt),
        .instr_class  (dec_class),
        .alu_function (dec_alu_function),
        .word_size    (dec_word_size),
        .load_signed  (dec_load_signed),
        .is_signed    (dec_is_signed),
        .is_lui       (dec_is_lui),
        .is_jump_reg  (dec_is_jump_reg)
    );

    always_comb begin
        state_d               = state_q;
        pc_write              = 1'b0;
        pc_write_cond         = 1'b0;
        ir_write              = 1'b0;
        mem_read              = 1'b0;
        mem_write             = 1'b0;
        reg_write_enabled     = 1'b0;
        uses_immediate_in_alu = 1'b0;
        is_r_type             = 1'b0;
        is_link               = 1'b0;
        is_jump_reg           = 1'b0;
        is_lui                = 1'b0;
        is_signed             = 1'b1;
        load_signed           = 1'b0;
        alu_function          = '0;
        word_size             = 2'b11;
        instr_retired         = 1'b0;

        // Selects follow the decoder for the whole life of the instruction after FETCH
        if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_function          = dec_alu_function;
            word_size             = dec_word_size;
            load_signed           = dec_load_signed;
            is_signed             = dec_is_signed;
            is_lui                = dec_is_lui;
            is_jump_reg           = dec_is_jump_reg;
            is_r_type             = (dec_class == CL_ALU);
            is_link               = (dec_class == CL_JUMP_LINK);
            uses_immediate_in_alu = (dec_class == CL_ALUI) || (dec_class == CL_LOAD) ||
                                    (dec_class == CL_STORE);
        end

        case (state_q)
            S_FETCH: begin
                mem_read     = 1'b1;
                alu_function = F_ADD;
                ir_write     = mem_ok;
                pc_write     = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: state_d = (dec_class == CL_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (dec_class)
                    CL_ALU, CL_ALUI:     state_d = S_WB;
                    CL_LOAD, CL_STORE:   state_d = S_MEM;
                    CL_BRANCH: begin
                        pc_write_cond = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                    CL_JUMP: begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                    CL_JUMP_LINK: begin
                        pc_write = 1'b1;
                        state_d  = S_WB;
                    end
                    default:             state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_read  = (dec_class == CL_LOAD);
                mem_write = (dec_class != CL_LOAD);
                if (mem_ok) begin
                    if (dec_class == CL_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write_enabled = 1'b1;
                instr_retired     = 1'b1;
                state_d           = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // While reset is held the outputs show their reset values rather than the FETCH strobes
        if (reset) begin
            pc_write              = 1'b0;
            pc_write_cond         = 1'b0;
            ir_write              = 1'b0;
            mem_read              = 1'b0;
            mem_write             = 1'b0;
            reg_write_enabled     = 1'b0;
            uses_immediate_in_alu = 1'b0;
            is_r_type             = 1'b0;
            is_link               = 1'b0;
            is_jump_reg           = 1'b0;
            is_lui                = 1'b0;
            is_signed             = 1'b1;
            load_signed           = 1'b0;
            alu_function          = '0;
            word_size             = 2'b11;
            instr_retired         = 1'b0;
        end

        retired_count_d = retired_count_q + CNT_W'(instr_retired);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FETCH;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign state         = state_q;
    assign retired_count = retired_count_q;
    assign illegal_instr = (state_q == S_TRAP) && !reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a 4-bit retire counter to exercise wrap.
// Expected values are hand-computed from the instruction sequencing rules.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_in;
    logic [5:0] funct_in;
    logic [4:0] rt;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write_enabled;
    logic       uses_immediate_in_alu, is_r_type, is_link, is_jump_reg, is_lui, is_signed, load_signed;
    logic [5:0] alu_function;
    logic [1:0] word_size;
    logic [2:0] state;
    logic       instr_retired;
    logic [3:0] retired_count;
    logic       illegal_instr;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    multicycle_control #(.W(6), .CNT_W(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .opcode_in             (opcode_in),
        .funct_in              (funct_in),
        .rt                    (rt),
        .mem_ready             (mem_ready),
        .pc_write              (pc_write),
        .pc_write_cond         (pc_write_cond),
        .ir_write              (ir_write),
        .mem_read              (mem_read),
        .mem_write             (mem_write),
        .reg_write_enabled     (reg_write_enabled),
        .uses_immediate_in_alu (uses_immediate_in_alu),
        .is_r_type             (is_r_type),
        .is_link               (is_link),
        .is_jump_reg           (is_jump_reg),
        .is_lui                (is_lui),
        .is_signed             (is_signed),
        .load_signed           (load_signed),
        .alu_function          (alu_function),
        .word_size             (word_size),
        .state                 (state),
        .instr_retired         (instr_retired),
        .retired_count         (retired_count),
        .illegal_instr         (illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt_v);
        opcode_in = op;
        funct_in  = fn;
        rt        = rt_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        applyStimulus(6'h00, 6'h00, 5'd0);
        tick();
        tick();

        // Reset values while reset is held
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_pc_write", 32'(pc_write), 32'd0);
        checkOutput("rst_ir_write", 32'(ir_write), 32'd0);
        checkOutput("rst_alu", 32'(alu_function), 32'h00);
        checkOutput("rst_word_size", 32'(word_size), 32'd3);
        checkOutput("rst_is_signed", 32'(is_signed), 32'd1);
        checkOutput("rst_count", 32'(retired_count), 32'd0);
        checkOutput("rst_illegal", 32'(illegal_instr), 32'd0);
        checkOutput("rst_retired", 32'(instr_retired), 32'd0);

        reset = 1'b0;
        #1;
        checkOutput("fetch_mem_read", 32'(mem_read), 32'd1);
        checkOutput("fetch_ir_write", 32'(ir_write), 32'd1);
        checkOutput("fetch_alu", 32'(alu_function), 32'h20);

        // ADD
        applyStimulus(6'h00, 6'h20, 5'd0);
        tick();
        checkOutput("add_decode_state", 32'(state), 32'd1);
        checkOutput("add_decode_regw", 32'(reg_write_enabled), 32'd0);
        tick();
        checkOutput("add_exec_state", 32'(state), 32'd2);
        checkOutput("add_exec_alu", 32'(alu_function), 32'h20);
        checkOutput("add_exec_rtype", 32'(is_r_type), 32'd1);
        checkOutput("add_exec_regw", 32'(reg_write_enabled), 32'd0);
        tick();
        checkOutput("add_wb_state", 32'(state), 32'd4);
        checkOutput("add_wb_regw", 32'(reg_write_enabled), 32'd1);
        checkOutput("add_wb_retired", 32'(instr_retired), 32'd1);
        tick();
        checkOutput("add_done_state", 32'(state), 32'd0);
        checkOutput("add_done_count", 32'(retired_count), 32'd1);
        checkOutput("add_done_regw", 32'(reg_write_enabled), 32'd0);

        // LH: five cycles, signed, full word size
        applyStimulus(6'h21, 6'h00, 5'd0);
        tick();
        tick();
        checkOutput("lh_exec_alu", 32'(alu_function), 32'h20);
        checkOutput("lh_exec_imm", 32'(uses_immediate_in_alu), 32'd1);
        tick();
        checkOutput("lh_mem_state", 32'(state), 32'd3);
        checkOutput("lh_mem_read", 32'(mem_read), 32'd1);
        checkOutput("lh_mem_wsize", 32'(word_size), 32'd3);
        checkOutput("lh_mem_lsigned", 32'(load_signed), 32'd1);
        tick();
        checkOutput("lh_wb_state", 32'(state), 32'd4);
        checkOutput("lh_wb_regw", 32'(reg_write_enabled), 32'd1);
        tick();
        checkOutput("lh_done_state", 32'(state), 32'd0);
        checkOutput("lh_done_count", 32'(retired_count), 32'd2);

        // SB: store byte, no WB
        applyStimulus(6'h28, 6'h00, 5'd0);
        tick();
        tick();
        tick();
        checkOutput("sb_mem_state", 32'(state), 32'd3);
        checkOutput("sb_mem_write", 32'(mem_write), 32'd1);
        checkOutput("sb_mem_read", 32'(mem_read), 32'd0);
        checkOutput("sb_mem_wsize", 32'(word_size), 32'd0);
        checkOutput("sb_mem_retired", 32'(instr_retired), 32'd1);
        tick();
        checkOutput("sb_done_state", 32'(state), 32'd0);
        checkOutput("sb_done_count", 32'(retired_count), 32'd3);

        // BGEZ
        applyStimulus(6'h01, 6'h00, 5'd1);
        tick();
        tick();
        checkOutput("bgez_exec_state", 32'(state), 32'd2);
        checkOutput("bgez_exec_pcc", 32'(pc_write_cond), 32'd1);
        checkOutput("bgez_exec_alu", 32'(alu_function), 32'h39);
        checkOutput("bgez_exec_pcw", 32'(pc_write), 32'd0);
        tick();
        checkOutput("bgez_done_state", 32'(state), 32'd0);
        checkOutput("bgez_done_count", 32'(retired_count), 32'd4);

        // REGIMM with rt=5 traps and stays trapped
        applyStimulus(6'h01, 6'h00, 5'd5);
        tick();
        checkOutput("trap_decode_state", 32'(state), 32'd1);
        tick();
        checkOutput("trap_state", 32'(state), 32'd7);
        checkOutput("trap_illegal", 32'(illegal_instr), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("trap_held_state", 32'(state), 32'd7);
        checkOutput("trap_held_illegal", 32'(illegal_instr), 32'd1);
        checkOutput("trap_mem_read", 32'(mem_read), 32'd0);
        checkOutput("trap_pc_write", 32'(pc_write), 32'd0);
        checkOutput("trap_count", 32'(retired_count), 32'd4);

        reset = 1'b1;
        tick();
        checkOutput("trap_rst_state", 32'(state), 32'd0);
        checkOutput("trap_rst_illegal", 32'(illegal_instr), 32'd0);
        checkOutput("trap_rst_count", 32'(retired_count), 32'd0);
        reset = 1'b0;

        // LW with mem_ready low for three cycles of MEM
        applyStimulus(6'h23, 6'h00, 5'd0);
        tick();
        tick();
        tick();
        checkOutput("lw_mem_state", 32'(state), 32'd3);
        mem_ready = 1'b0;
        tick();
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
        checkOutput("lw_wait1_state", 32'(state), 32'd3);
        checkOutput("lw_wait1_read", 32'(mem_read), 32'd1);
        tick();
        tick();
        checkOutput("lw_wait3_state", 32'(state), 32'd3);
        mem_ready = 1'b1;
        tick();
        checkOutput("lw_wb_state", 32'(state), 32'd4);
`else
        checkOutput("lw_wb_state", 32'(state), 32'd4);
        mem_ready = 1'b1;
`endif
        tick();
        checkOutput("lw_done_state", 32'(state), 32'd0);
        checkOutput("lw_done_count", 32'(retired_count), 32'd1);

        // Reset in the middle of MEM abandons the load
        applyStimulus(6'h23, 6'h00, 5'd0);
        tick();
        tick();
        tick();
        checkOutput("mid_mem_state", 32'(state), 32'd3);
        checkOutput("mid_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_state", 32'(state), 32'd0);
        checkOutput("mid_rst_read", 32'(mem_read), 32'd0);
        checkOutput("mid_rst_count", 32'(retired_count), 32'd0);
        checkOutput("mid_rst_retired", 32'(instr_retired), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mid_rel_read", 32'(mem_read), 32'd1);

        // Sixteen J instructions wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            applyStimulus(6'h02, 6'h00, 5'd0);
            tick();
            tick();
            checkOutput("j_exec_pcw", 32'(pc_write), 32'd1);
            if (instr_retired === 1'b1) pulses++;
            if (i == 15) checkOutput("j_pre_wrap_count", 32'(retired_count), 32'd15);
            tick();
            checkOutput("j_count", 32'(retired_count), 32'((i + 1) % 16));
        end
        checkOutput("j_pulses", 32'(pulses), 32'd16);
        checkOutput("j_wrap_count", 32'(retired_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
